// File: rtl/alu_result_fifo_if.sv
// Push/pop handshake bundle between the ALU, the result FIFO and its consumer.
// master = producer/consumer side, slave = FIFO side.
interface alu_result_fifo_if #(
    parameter int N = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N+1:0] in_result;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N+1:0] out_result;
    logic [2:0]   out_op;
    logic         out_zero;
    logic         out_neg;

    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_neg
    );
endinterface

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO buffering signed ALU results with their opcode and
// zero/negative flags computed at push time.
module alu_result_fifo #(
    parameter int N     = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = N + 2;
    localparam int EW = RW + 5;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Entry layout: {result, op, zero, neg}
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          drop_err_reg, drop_err_next;

    logic          full, empty, push, pop;
    logic [EW-1:0] wr_entry, head;

    // in_ready comes only from the registered count, never from out_ready
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;

    assign wr_entry = {bus.in_result, bus.in_op, (bus.in_result == '0), bus.in_result[RW-1]};

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        drop_err_next = drop_err_reg | (bus.in_valid & full);
        if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_err_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            drop_err_reg <= drop_err_next;
        end
    end

    // Storage is not reset; stale entries are hidden by out_valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_entry;
    end

    assign head = mem[rd_ptr_reg];

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = ~empty;
    assign bus.out_result = head[EW-1 -: RW];
    assign bus.out_op     = head[4:2];
    assign bus.out_zero   = head[1];
    assign bus.out_neg    = head[0];
    assign count          = count_reg;
    assign drop_err       = drop_err_reg;
endmodule
